// File: rtl/prf_wb_queue_pkg.sv
// Shared writeback-queue types and sizing constants, reused by PRF-side consumers.
package prf_wb_queue_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PRF   = 64;
  localparam int unsigned NFU   = 6;
  localparam int unsigned DEPTH = 8;

  localparam int unsigned TAGW = $clog2(PRF);
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned OFFW = $clog2(NFU + 1);

  typedef struct packed {
    logic [TAGW-1:0] idx;
    logic [XLEN-1:0] dat;
  } wb_entry_t;

endpackage

// File: rtl/prf_wb_compact.sv
// Prefix-sum compactor: gives every accepted source its slot offset from tail.
module prf_wb_compact
  import prf_wb_queue_pkg::*;
(
  input  logic [NFU-1:0]           accept_i,
  output logic [NFU-1:0][OFFW-1:0] offset_o,
  output logic [OFFW-1:0]          total_o
);

  logic [OFFW-1:0] sum;

  always_comb begin
    sum      = '0;
    offset_o = '0;
    for (int unsigned i = 0; i < NFU; i++) begin
      offset_o[i] = sum;
      sum         = sum + OFFW'(accept_i[i]);
    end
    total_o = sum;
  end

endmodule

// File: rtl/prf_wb_queue.sv
// Writeback queue: buffers FU results in a circular FIFO and drains up to WAYS
// per cycle, oldest first, onto registered PRF write ports.
module prf_wb_queue
  import prf_wb_queue_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NFU-1:0]            fu_valid,
  input  logic [NFU-1:0][TAGW-1:0]  fu_idx,
  input  logic [NFU-1:0][XLEN-1:0]  fu_dat,
  output logic [NFU-1:0]            fu_ready,
  output logic [WAYS-1:0]           wr_en,
  output logic [WAYS-1:0][TAGW-1:0] wr_idx,
  output logic [WAYS-1:0][XLEN-1:0] wr_dat,
  output logic [CNTW-1:0]           count
);

  wb_entry_t mem_q [DEPTH];

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d, n_out;
  logic [CNTW:0]   free;

  logic [WAYS-1:0]           wr_en_q, wr_en_d;
  logic [WAYS-1:0][TAGW-1:0] wr_idx_q, wr_idx_d;
  logic [WAYS-1:0][XLEN-1:0] wr_dat_q, wr_dat_d;

  logic [NFU-1:0]           accept;
  logic [NFU-1:0][OFFW-1:0] offset;
  logic [OFFW-1:0]          n_in;
  logic                     clear;

  assign clear = reset | flush;

  // Ready uses the pre-dequeue count so enqueue can never overrun the storage.
  assign free = (CNTW+1)'(DEPTH) - {1'b0, count_q};

  always_comb begin
    fu_ready = '0;
    for (int unsigned i = 0; i < NFU; i++) begin
      fu_ready[i] = free > (CNTW+1)'(i);
    end
  end

  assign accept = fu_valid & fu_ready;
  assign n_out  = (count_q < CNTW'(WAYS)) ? count_q : CNTW'(WAYS);

  prf_wb_compact u_compact (
    .accept_i (accept),
    .offset_o (offset),
    .total_o  (n_in)
  );

  always_comb begin
    head_d   = head_q + PTRW'(n_out);
    tail_d   = tail_q + PTRW'(n_in);
    count_d  = count_q + CNTW'(n_in) - n_out;
    wr_en_d  = '0;
    wr_idx_d = '0;
    wr_dat_d = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (CNTW'(k) < n_out) begin
        wr_en_d[k]  = 1'b1;
        wr_idx_d[k] = mem_q[head_q + PTRW'(k)].idx;
        wr_dat_d[k] = mem_q[head_q + PTRW'(k)].dat;
      end
    end
    if (clear) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      wr_en_d  = '0;
      wr_idx_d = '0;
      wr_dat_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    head_q   <= head_d;
    tail_q   <= tail_d;
    count_q  <= count_d;
    wr_en_q  <= wr_en_d;
    wr_idx_q <= wr_idx_d;
    wr_dat_q <= wr_dat_d;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int unsigned i = 0; i < NFU; i++) begin
        if (accept[i]) begin
          mem_q[tail_q + PTRW'(offset[i])] <= '{idx: fu_idx[i], dat: fu_dat[i]};
        end
      end
    end
  end

  assign wr_en  = wr_en_q;
  assign wr_idx = wr_idx_q;
  assign wr_dat = wr_dat_q;
  assign count  = count_q;

endmodule

// File: tb/tb_prf_wb_queue.sv
// Scoreboard bench for prf_wb_queue: an occupancy/FIFO model predicts ready,
// count and the ordered write stream; a monitor checks wr_* each cycle.
module tb_prf_wb_queue;
  import prf_wb_queue_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      flush = 1'b0;
  logic [NFU-1:0]            fu_valid = '0;
  logic [NFU-1:0][TAGW-1:0]  fu_idx = '0;
  logic [NFU-1:0][XLEN-1:0]  fu_dat = '0;
  logic [NFU-1:0]            fu_ready;
  logic [WAYS-1:0]           wr_en;
  logic [WAYS-1:0][TAGW-1:0] wr_idx;
  logic [WAYS-1:0][XLEN-1:0] wr_dat;
  logic [CNTW-1:0]           count;

  prf_wb_queue dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_idx   (fu_idx),
    .fu_dat   (fu_dat),
    .fu_ready (fu_ready),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_dat   (wr_dat),
    .count    (count)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned occ     = 0;   // entries held in the queue, excluding wr_* registers
  bit          active  = 1'b0;

  wb_entry_t   sb_q[$];       // accepted results not yet written, oldest first
  int unsigned nout_q[$];     // expected number of writes after each edge

  task automatic step(input logic fl, input logic [NFU-1:0] v,
                      input logic [NFU-1:0][TAGW-1:0] ix,
                      input logic [NFU-1:0][XLEN-1:0] dt);
    logic [NFU-1:0] exp_ready;
    int unsigned nin, nout;
    @(negedge clock);
    flush = fl; fu_valid = v; fu_idx = ix; fu_dat = dt;
    vectors++;
    for (int unsigned i = 0; i < NFU; i++) exp_ready[i] = (DEPTH - occ) > i;
    if (fu_ready !== exp_ready) begin
      errors++;
      $display("FAIL fu_ready: got %b expected %b", fu_ready, exp_ready);
    end
    if (count !== CNTW'(occ)) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", count, occ);
    end
    nout = (occ < WAYS) ? occ : WAYS;
    if (fl) begin
      sb_q.delete();
      nout_q.push_back(0);
      occ = 0;
    end else begin
      nin = 0;
      for (int unsigned i = 0; i < NFU; i++) begin
        if (v[i] && exp_ready[i]) begin
          sb_q.push_back('{idx: ix[i], dat: dt[i]});
          nin++;
        end
      end
      nout_q.push_back(nout);
      occ = occ + nin - nout;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned c = 0; c < n; c++) step(1'b0, '0, '0, '0);
  endtask

  // Monitor: compares what the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (active && nout_q.size() > 0) begin
        int unsigned n;
        logic [WAYS-1:0] exp_en;
        wb_entry_t e;
        n = nout_q.pop_front();
        for (int unsigned k = 0; k < WAYS; k++) exp_en[k] = (k < n);
        if (wr_en !== exp_en) begin
          errors++;
          $display("FAIL wr_en: got %b expected %b", wr_en, exp_en);
        end
        for (int unsigned k = 0; k < WAYS; k++) begin
          if (k < n) begin
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL sb_underflow: way %0d has no expected entry", k);
            end else begin
              e = sb_q.pop_front();
              if (wr_idx[k] !== e.idx || wr_dat[k] !== e.dat) begin
                errors++;
                $display("FAIL wr_data way %0d: got idx %0d dat %h expected idx %0d dat %h",
                         k, wr_idx[k], wr_dat[k], e.idx, e.dat);
              end
            end
          end else if (wr_idx[k] !== '0 || wr_dat[k] !== '0) begin
            errors++;
            $display("FAIL idle_way %0d: got idx %0d dat %h expected 0", k, wr_idx[k], wr_dat[k]);
          end
        end
      end
    end
  end

  initial begin
    logic [NFU-1:0][TAGW-1:0] ix;
    logic [NFU-1:0][XLEN-1:0] dt;
    logic [NFU-1:0]           v;

    repeat (2) @(negedge clock);
    vectors++;
    if (count !== '0 || fu_ready !== '1 || wr_en !== '0 || wr_idx !== '0 || wr_dat !== '0) begin
      errors++;
      $display("FAIL reset_state: count %0d ready %b wr_en %b wr_idx %h wr_dat %h expected 0/all-ones/0/0/0",
               count, fu_ready, wr_en, wr_idx, wr_dat);
    end
    reset  = 1'b0;
    active = 1'b1;
    idle(10);

    // Burst of six tags 10..15 into an empty queue.
    for (int unsigned i = 0; i < NFU; i++) begin
      ix[i] = TAGW'(10 + i);
      dt[i] = 32'hA000_0000 + i;
    end
    step(1'b0, '1, ix, dt);
    idle(4);

    // Head and tail now sit at 6: four results straddle the wrap point.
    for (int unsigned i = 0; i < NFU; i++) begin
      ix[i] = TAGW'(20 + i);
      dt[i] = 32'hB000_0000 + i;
    end
    step(1'b0, 6'b001111, ix, dt);
    idle(3);

    // Back-to-back full bursts exercise partial readiness.
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned i = 0; i < NFU; i++) begin
        ix[i] = TAGW'(30 + 6 * r + i);
        dt[i] = 32'hC000_0000 + 16 * r + i;
      end
      step(1'b0, '1, ix, dt);
    end
    idle(4);

    // Five buffered, then flush with three more valid.
    for (int unsigned i = 0; i < NFU; i++) begin
      ix[i] = TAGW'(50 + i);
      dt[i] = 32'hD000_0000 + i;
    end
    step(1'b0, 6'b011111, ix, dt);
    step(1'b1, 6'b000111, ix, dt);
    idle(4);

    for (int unsigned c = 0; c < 10000; c++) begin
      for (int unsigned i = 0; i < NFU; i++) begin
        ix[i] = TAGW'($urandom);
        dt[i] = $urandom;
      end
      case ($urandom_range(0, 3))
        0:       v = NFU'($urandom) & NFU'($urandom);
        1:       v = NFU'($urandom);
        default: v = NFU'($urandom) | NFU'($urandom);
      endcase
      step($urandom_range(0, 63) == 0, v, ix, dt);
    end
    idle(4);
    @(posedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
